cmos_sensor_tx: RTL and testbench

//  Synthesizable OV7670-style sensor transmitter: drives VSYNC/HREF/8-bit RGB565 byte stream in the

---
 rtl/cmos_sensor_tx_pkg.sv | 49 ++++
 rtl/cmos_sensor_tx_bar_gen.sv | 24 ++
 rtl/cmos_sensor_tx.sv | 181 ++++++++++++++++++
 tb/tb_cmos_sensor_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_sensor_tx_pkg.sv
// Shared definitions for the CMOS sensor transmitter and its capture-side peers.
// Contents:
//   tx_state_t      - frame-level FSM encoding (IDLE/SYNC/BACK/ACTIVE/FRONT)
//   DEF_*           - default 640x480 timing, shared with the capture block
//   RGB_*           - RGB565 colour-bar palette, left to right
//   bar_color()     - bar index (0..7) -> RGB565 colour
package cmos_sensor_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } tx_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 288;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] rgb;
        case (bar)
            3'd0:    rgb = RGB_WHITE;
            3'd1:    rgb = RGB_YELLOW;
            3'd2:    rgb = RGB_CYAN;
            3'd3:    rgb = RGB_GREEN;
            3'd4:    rgb = RGB_MAGENTA;
            3'd5:    rgb = RGB_RED;
            3'd6:    rgb = RGB_BLUE;
            3'd7:    rgb = RGB_BLACK;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/cmos_sensor_tx_bar_gen.sv
// Colour-bar pattern source: maps a pixel index within the active line to
// one of eight equal-width RGB565 bars. Purely combinational.
// Ports:
//   pix_idx  in  PIX_W  pixel index within the line (0..H_ACTIVE-1)
//   rgb      out 16     RGB565 colour of the bar containing pix_idx
module cmos_sensor_tx_bar_gen
    import cmos_sensor_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int PIX_W    = $clog2(DEF_H_ACTIVE)
) (
    input  logic [PIX_W-1:0] pix_idx,
    output logic [15:0]      rgb
);

    logic [2:0] bar_s;

    // Bar index is the pixel index divided by the bar width (H_ACTIVE/8).
    always_comb begin
        bar_s = 3'(pix_idx / PIX_W'(H_ACTIVE / 8));
        rgb   = bar_color(bar_s);
    end

endmodule

// File: rtl/cmos_sensor_tx.sv
// OV7670-style sensor transmitter: emits VSYNC/HREF and an RGB565 byte stream
// (high byte first) in the CMOS_PCLK domain, sourced from internal colour bars
// or an external pixel source read with a one-cycle strobe.
// Ports:
//   CMOS_PCLK    in   1   byte clock, all outputs registered on posedge
//   iRST_N       in   1   asynchronous active-low reset
//   iEN          in   1   stream frames (sampled at frame boundary only)
//   iMODE        in   1   0 colour bars, 1 external pixels (sampled at SYNC entry)
//   oPIX_REQ     out  1   read strobe, two cycles ahead of the pixel's high byte
//   iPIX_DATA    in   16  external pixel, valid the cycle after oPIX_REQ
//   CMOS_VSYNC   out  1   high during sync lines and while idle
//   CMOS_HREF    out  1   high for 2*H_ACTIVE cycles on active lines
//   CMOS_DATA    out  8   byte stream, 0 outside HREF
//   oFRAME_DONE  out  1   pulse on the last cycle of each frame
//   oFRAME_CNT   out  8   completed frames, wrapping
module cmos_sensor_tx
    import cmos_sensor_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT
) (
    input  logic        CMOS_PCLK,
    input  logic        iRST_N,
    input  logic        iEN,
    input  logic        iMODE,
    output logic        oPIX_REQ,
    input  logic [15:0] iPIX_DATA,
    output logic        CMOS_VSYNC,
    output logic        CMOS_HREF,
    output logic [7:0]  CMOS_DATA,
    output logic        oFRAME_DONE,
    output logic [7:0]  oFRAME_CNT
);

    localparam int LINE_T = 2 * H_ACTIVE + H_BLANK;
    localparam int BC_W   = $clog2(LINE_T);
    localparam int LC_W   = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT + 1);
    localparam int PIX_W  = $clog2(H_ACTIVE);

    tx_state_t         state_r, next_state_s;
    logic [BC_W-1:0]   bc_r, next_bc_s;
    logic [LC_W-1:0]   lc_r, next_lc_s;
    logic              last_line_s;
    logic              mode_r;
    logic [7:0]        hold_lo_r;
    logic              next_href_s, next_hi_byte_s, before_active_s;
    logic              next_req_s, next_done_s;
    logic [7:0]        next_data_s;
    logic [PIX_W-1:0]  pix_idx_s;
    logic [15:0]       bar_rgb_s;
    logic              vsync_r, href_r, req_r, done_r;
    logic [7:0]        data_r, frame_cnt_r;

    // Flags the final line of the current vertical region.
    always_comb begin
        case (state_r)
            ST_SYNC:   last_line_s = (lc_r == LC_W'(V_SYNC - 1));
            ST_BACK:   last_line_s = (lc_r == LC_W'(V_BACK - 1));
            ST_ACTIVE: last_line_s = (lc_r == LC_W'(V_ACTIVE - 1));
            ST_FRONT:  last_line_s = (lc_r == LC_W'(V_FRONT - 1));
            default:   last_line_s = 1'b0;
        endcase
    end

    // Next frame position: byte counter within line, line counter within region, region.
    always_comb begin
        next_state_s = state_r;
        next_bc_s    = bc_r;
        next_lc_s    = lc_r;
        if (state_r == ST_IDLE) begin
            next_bc_s = {BC_W{1'b0}};
            next_lc_s = {LC_W{1'b0}};
            if (iEN) begin
                next_state_s = ST_SYNC;
            end else begin
                next_state_s = ST_IDLE;
            end
        end else if (bc_r == BC_W'(LINE_T - 1)) begin
            next_bc_s = {BC_W{1'b0}};
            if (last_line_s) begin
                next_lc_s = {LC_W{1'b0}};
                case (state_r)
                    ST_SYNC:   next_state_s = ST_BACK;
                    ST_BACK:   next_state_s = ST_ACTIVE;
                    ST_ACTIVE: next_state_s = ST_FRONT;
                    ST_FRONT:  next_state_s = iEN ? ST_SYNC : ST_IDLE;
                    default:   next_state_s = ST_IDLE;
                endcase
            end else begin
                next_lc_s = lc_r + LC_W'(1);
            end
        end else begin
            next_bc_s = bc_r + BC_W'(1);
        end
    end

    // Pixel under the byte about to be driven.
    always_comb begin
        pix_idx_s = PIX_W'(next_bc_s >> 1);
    end

    cmos_sensor_tx_bar_gen #(
        .H_ACTIVE (H_ACTIVE),
        .PIX_W    (PIX_W)
    ) u_bar_gen (
        .pix_idx (pix_idx_s),
        .rgb     (bar_rgb_s)
    );

    // Output values for the next position. The read strobe leads the high byte by
    // two cycles, so pixel 0 is requested two cycles before the end of the line
    // preceding every active line (including the last back-porch line).
    always_comb begin
        next_href_s     = (next_state_s == ST_ACTIVE) && (next_bc_s < BC_W'(2 * H_ACTIVE));
        next_hi_byte_s  = ~next_bc_s[0];
        before_active_s = ((next_state_s == ST_BACK) && (next_lc_s == LC_W'(V_BACK - 1))) ||
                          ((next_state_s == ST_ACTIVE) && (next_lc_s != LC_W'(V_ACTIVE - 1)));
        next_req_s      = mode_r &&
                          ((next_href_s && next_hi_byte_s && (next_bc_s < BC_W'(2 * H_ACTIVE - 2))) ||
                           ((next_bc_s == BC_W'(LINE_T - 2)) && before_active_s));
        next_done_s     = (next_state_s == ST_FRONT) && (next_lc_s == LC_W'(V_FRONT - 1)) &&
                          (next_bc_s == BC_W'(LINE_T - 1));
        if (!next_href_s) begin
            next_data_s = 8'h00;
        end else if (mode_r) begin
            // High byte goes straight out from the source; low byte comes from the hold register.
            next_data_s = next_hi_byte_s ? iPIX_DATA[15:8] : hold_lo_r;
        end else begin
            next_data_s = next_hi_byte_s ? bar_rgb_s[15:8] : bar_rgb_s[7:0];
        end
    end

    // Frame FSM, counters and registered outputs.
    always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r     <= ST_IDLE;
            bc_r        <= {BC_W{1'b0}};
            lc_r        <= {LC_W{1'b0}};
            mode_r      <= 1'b0;
            hold_lo_r   <= 8'h00;
            vsync_r     <= 1'b1;
            href_r      <= 1'b0;
            data_r      <= 8'h00;
            req_r       <= 1'b0;
            done_r      <= 1'b0;
            frame_cnt_r <= 8'h00;
        end else begin
            state_r <= next_state_s;
            bc_r    <= next_bc_s;
            lc_r    <= next_lc_s;
            if ((state_r != ST_SYNC) && (next_state_s == ST_SYNC)) begin
                mode_r <= iMODE;
            end
            // The pixel is captured on the edge that starts its high byte; only the
            // low half has to be kept for the following cycle.
            if (next_href_s && next_hi_byte_s) begin
                hold_lo_r <= iPIX_DATA[7:0];
            end
            vsync_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_SYNC);
            href_r  <= next_href_s;
            data_r  <= next_data_s;
            req_r   <= next_req_s;
            done_r  <= next_done_s;
            if (next_done_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    assign CMOS_VSYNC  = vsync_r;
    assign CMOS_HREF   = href_r;
    assign CMOS_DATA   = data_r;
    assign oPIX_REQ    = req_r;
    assign oFRAME_DONE = done_r;
    assign oFRAME_CNT  = frame_cnt_r;

endmodule

// File: tb/tb_cmos_sensor_tx.sv
// Self-checking bench for cmos_sensor_tx with small timing (LINE_T=20, frame=140).
// A frame-time reference model predicts every output each cycle; an external
// pixel source answers read strobes and queues the values it supplied.
module tb_cmos_sensor_tx;

    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 4;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 1;
    localparam int V_ACTIVE = 4;
    localparam int V_FRONT  = 1;
    localparam int LINE_T   = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_T  = LINE_T * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        pix_req;
    logic [15:0] pix_data;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        done;
    logic [7:0]  fcnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_run = 1'b0;
    int          m_t = 0;
    bit          m_mode = 1'b0;
    logic [7:0]  m_cnt = 8'd0;
    logic [15:0] exp_q[$];

    // pixel source and observation counters
    bit          pend = 1'b0;
    bit          use_cnt = 1'b0;
    int          pix_n = 0;
    int          vs_n = 0, href_n = 0, req_n = 0, done_n = 0;
    bit          wrap_seen = 1'b0;

    always #5 clk = ~clk;

    cmos_sensor_tx #(
        .H_ACTIVE (H_ACTIVE), .H_BLANK (H_BLANK), .V_SYNC (V_SYNC),
        .V_BACK (V_BACK), .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT)
    ) dut (
        .CMOS_PCLK   (clk),
        .iRST_N      (rst_n),
        .iEN         (en),
        .iMODE       (mode),
        .oPIX_REQ    (pix_req),
        .iPIX_DATA   (pix_data),
        .CMOS_VSYNC  (vsync),
        .CMOS_HREF   (href),
        .CMOS_DATA   (data),
        .oFRAME_DONE (done),
        .oFRAME_CNT  (fcnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_href(int t);
        int line;
        int bc;
        line = t / LINE_T;
        bc   = t % LINE_T;
        return (t < FRAME_T) && (line >= V_SYNC + V_BACK) &&
               (line < V_SYNC + V_BACK + V_ACTIVE) && (bc < 2 * H_ACTIVE);
    endfunction

    // A high byte is an even byte slot of an active line.
    function automatic bit is_high_byte(int t);
        return is_href(t) && ((t % LINE_T) % 2 == 0);
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_t   = 0;
        m_cnt = 8'd0;
        exp_q.delete();
        pend  = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic e, input logic md);
        if (!r) begin
            model_reset();
        end else if (!m_run) begin
            if (e) begin
                m_run = 1'b1; m_t = 0; m_mode = md;
            end
        end else begin
            m_t++;
            if (m_t == FRAME_T) begin
                if (e) begin
                    m_t = 0; m_mode = md;
                end else begin
                    m_run = 1'b0; m_t = 0;
                end
            end
        end
        if (m_run && m_t == FRAME_T - 1) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic check_outputs();
        bit         e_href;
        int         k;
        logic [7:0] e_data;
        e_href = m_run && is_href(m_t);
        k      = m_t % LINE_T;
        chk("vsync", vsync, !m_run || (m_t < V_SYNC * LINE_T));
        chk("href", href, e_href);
        chk("pix_req", pix_req, m_run && m_mode && is_high_byte(m_t + 2));
        chk("frame_done", done, m_run && (m_t == FRAME_T - 1));
        chk("frame_cnt", fcnt, m_cnt);
        if (!e_href) begin
            e_data = 8'h00;
        end else if (!m_mode) begin
            e_data = (k % 2 == 0) ? BARS[(k / 2) / (H_ACTIVE / 8)][15:8]
                                  : BARS[(k / 2) / (H_ACTIVE / 8)][7:0];
        end else if (exp_q.size() == 0) begin
            chk("source_queue_nonempty", 16'd0, 16'd1);
            e_data = 8'h00;
        end else if (k % 2 == 0) begin
            e_data = exp_q[0][15:8];
        end else begin
            e_data = exp_q[0][7:0];
            void'(exp_q.pop_front());
        end
        chk("data", data, e_data);
        vs_n   += vsync;
        href_n += href;
        req_n  += pix_req;
        done_n += done;
        if (done && fcnt == 8'd0) wrap_seen = 1'b1;
    endtask

    // One clock: model follows the posedge, outputs are checked at the negedge,
    // then the pixel source answers a strobe seen one cycle earlier.
    task automatic step();
        logic r, e, md, nreq;
        logic [15:0] v;
        r = rst_n; e = en; md = mode;
        @(posedge clk);
        model_edge(r, e, md);
        @(negedge clk);
        check_outputs();
        nreq = pix_req;
        if (pend) begin
            v = use_cnt ? 16'(16'h1000 + pix_n) : 16'($urandom);
            pix_data = v;
            exp_q.push_back(v);
            pix_n++;
        end else begin
            pix_data = 16'($urandom);
        end
        pend = nreq;
    endtask

    task automatic clear_counts();
        vs_n = 0; href_n = 0; req_n = 0; done_n = 0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; pix_data = 16'h0000;
        // 1: reset and idle
        #12;
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_href", href, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_cnt", fcnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 30; i++) step();
        chk("idle_vsync_cycles", 16'(vs_n), 16'd30);
        chk("idle_req_count", 16'(req_n), 16'd0);

        // 2: one colour-bar frame
        en = 1'b1; mode = 1'b0;
        clear_counts();
        step();
        mode = 1'b1;
        for (int i = 1; i < FRAME_T; i++) step();
        chk("bars_vsync_cycles", 16'(vs_n), 16'd20);
        chk("bars_href_cycles", 16'(href_n), 16'd64);
        chk("bars_done_pulses", 16'(done_n), 16'd1);
        chk("bars_frame_cnt", fcnt, 8'd1);

        // 3: external counter pixels
        use_cnt = 1'b1; pix_n = 0;
        clear_counts();
        for (int i = 0; i < FRAME_T; i++) step();
        chk("ext_req_count", 16'(req_n), 16'd32);
        chk("ext_pixels_supplied", 16'(pix_n), 16'd32);
        chk("ext_frame_cnt", fcnt, 8'd2);
        use_cnt = 1'b0;

        // random modes and pixels for a few frames
        for (int i = 0; i < 3 * FRAME_T; i++) begin
            mode = 1'($urandom_range(0, 1));
            step();
        end

        // 4: drop enable during the second active line
        for (int i = 0; i < 2 * FRAME_T && !(m_run && m_t == 3 * LINE_T + 4); i++) step();
        chk("href_at_en_drop", href, 1'b1);
        en = 1'b0;
        clear_counts();
        for (int i = 0; i < 100; i++) step();
        chk("drop_done_pulses", 16'(done_n), 16'd1);
        chk("drop_idle_vsync", vsync, 1'b1);
        chk("drop_frame_cnt", fcnt, 8'd6);

        // 5: asynchronous reset in the middle of HREF
        en = 1'b1;
        for (int i = 0; i < 2 * FRAME_T && !(m_run && m_t == 3 * LINE_T + 5); i++) step();
        chk("href_before_reset", href, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_vsync", vsync, 1'b1);
        chk("async_rst_href", href, 1'b0);
        chk("async_rst_data", data, 8'h00);
        chk("async_rst_req", pix_req, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_cnt", fcnt, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < FRAME_T; i++) step();
        chk("restart_done_pulses", 16'(done_n), 16'd1);
        chk("restart_frame_cnt", fcnt, 8'd1);

        // 6: 256 frames, frame counter wrap
        clear_counts();
        wrap_seen = 1'b0;
        for (int i = 0; i < 256 * FRAME_T; i++) begin
            mode = 1'($urandom_range(0, 1));
            step();
        end
        chk("wrap_done_pulses", 16'(done_n), 16'd256);
        chk("wrap_frame_cnt", fcnt, 8'd1);
        chk("wrap_seen_zero", 16'(wrap_seen), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
